// File: rtl/uart_gen.sv
// uart_gen: parametrised full-duplex UART with configurable data width and stop bits.
// It also provides a 2-FF RXD synchroniser, a glitch-rejecting start detector and
// framing-error reporting.
// Defining UART_PARITY_EN adds a parity bit, the parity_odd and recv_perr ports,
// and the PARITY states.
module uart_gen #(
  parameter int CLK_DIV   = 1302,
  parameter int DIV_WIDTH = 11,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 uart_txd,
  input  logic                 uart_rxd,
  input  logic                 send_en,
  input  logic [DATA_BITS-1:0] send_data,
  output logic                 send_ready,
  output logic                 recv_en,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 recv_ferr
`ifdef UART_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 recv_perr
`endif
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [DIV_WIDTH-1:0] DIV_RELOAD  = DIV_WIDTH'(CLK_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] HALF_RELOAD = DIV_WIDTH'((CLK_DIV >> 1) - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(DATA_BITS - 1);
  localparam logic [0:0]           LAST_STOP   = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0]   tx_cnt, tx_cnt_n;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
  logic [IDX_W-1:0]       tx_idx, tx_idx_n;
  logic [0:0]             tx_stop, tx_stop_n;
  logic                   txd_q, txd_n;
`ifdef UART_PARITY_EN
  logic                   tx_par, tx_par_n;
`endif

  assign uart_txd   = txd_q;
  assign send_ready = (tx_state == TX_IDLE);

  // TX next-state logic: the divider only runs while a frame is in flight, and the
  // output bit is chosen from the next state so uart_txd comes straight from a flop.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_shift_n = tx_shift;
    tx_idx_n   = tx_idx;
    tx_stop_n  = tx_stop;
    txd_n      = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    if (tx_state == TX_IDLE) begin
      tx_cnt_n = DIV_RELOAD;
      if (send_en) begin
        tx_state_n = TX_START;
        tx_shift_n = send_data;
        tx_idx_n   = '0;
        tx_stop_n  = '0;
`ifdef UART_PARITY_EN
        tx_par_n   = (^send_data) ^ parity_odd;
`endif
      end
    end else if (tx_cnt != '0) begin
      tx_cnt_n = tx_cnt - DIV_WIDTH'(1);
    end else begin
      tx_cnt_n = DIV_RELOAD;
      case (tx_state)
        TX_START: tx_state_n = TX_DATA;
        TX_DATA: begin
          if (tx_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
          end else begin
            tx_shift_n = tx_shift >> 1;
            tx_idx_n   = tx_idx + IDX_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: tx_state_n = TX_STOP;
`endif
        TX_STOP: begin
          if (tx_stop == LAST_STOP) tx_state_n = TX_IDLE;
          else                      tx_stop_n  = tx_stop + 1'b1;
        end
        default: tx_state_n = TX_IDLE;
      endcase
    end

    case (tx_state_n)
      TX_START:  txd_n = 1'b0;
      TX_DATA:   txd_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
      TX_PARITY: txd_n = tx_par_n;
`endif
      default:   txd_n = 1'b1;
    endcase
  end

  // TX state register; reset aborts any frame and returns the line to idle-high.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= DIV_RELOAD;
      tx_shift <= '0;
      tx_idx   <= '0;
      tx_stop  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_shift <= tx_shift_n;
      tx_idx   <= tx_idx_n;
      tx_stop  <= tx_stop_n;
      txd_q    <= txd_n;
`ifdef UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // ---------------- receiver ----------------
  logic                   sync_q, rxs;
  rx_state_t              rx_state, rx_state_n;
  logic [DIV_WIDTH-1:0]   rx_cnt, rx_cnt_n;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
  logic [IDX_W-1:0]       rx_idx, rx_idx_n;
  logic                   recv_en_n, recv_ferr_n;
  logic [DATA_BITS-1:0]   recv_data_n;
`ifdef UART_PARITY_EN
  logic                   rx_perr, rx_perr_n, recv_perr_n;
`endif

  // Two-flop synchroniser for the asynchronous serial input; idles high.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      sync_q <= uart_rxd;
      rxs    <= sync_q;
    end
  end

  // RX next-state logic: sample at mid-bit, reject short start pulses, report the frame
  // on the first stop bit, and stall in WAIT_HIGH on a held-low line.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_shift_n  = rx_shift;
    rx_idx_n    = rx_idx;
    recv_en_n   = 1'b0;
    recv_data_n = recv_data;
    recv_ferr_n = recv_ferr;
`ifdef UART_PARITY_EN
    rx_perr_n   = rx_perr;
    recv_perr_n = recv_perr;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = DIV_RELOAD;
        if (!rxs) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_RELOAD;
        end
      end
      RX_WAIT_HIGH: begin
        rx_cnt_n = DIV_RELOAD;
        if (rxs) rx_state_n = RX_IDLE;
      end
      default: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - DIV_WIDTH'(1);
        end else begin
          rx_cnt_n = DIV_RELOAD;
          case (rx_state)
            RX_START: begin
              if (!rxs) begin
                rx_state_n = RX_DATA;
                rx_idx_n   = '0;
              end else begin
                rx_state_n = RX_IDLE;
              end
            end
            RX_DATA: begin
              rx_shift_n = {rxs, rx_shift[DATA_BITS-1:1]};
              if (rx_idx == LAST_IDX) begin
`ifdef UART_PARITY_EN
                rx_state_n = RX_PARITY;
`else
                rx_state_n = RX_STOP;
`endif
              end else begin
                rx_idx_n = rx_idx + IDX_W'(1);
              end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
              rx_perr_n  = rxs ^ (^rx_shift) ^ parity_odd;
              rx_state_n = RX_STOP;
            end
`endif
            RX_STOP: begin
              recv_en_n   = 1'b1;
              recv_data_n = rx_shift;
              recv_ferr_n = ~rxs;
`ifdef UART_PARITY_EN
              recv_perr_n = rx_perr;
`endif
              rx_state_n  = rxs ? RX_IDLE : RX_WAIT_HIGH;
            end
            default: rx_state_n = RX_IDLE;
          endcase
        end
      end
    endcase
  end

  // RX state and output registers; reset drops any partial frame without a pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= DIV_RELOAD;
      rx_shift  <= '0;
      rx_idx    <= '0;
      recv_en   <= 1'b0;
      recv_data <= '0;
      recv_ferr <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr   <= 1'b0;
      recv_perr <= 1'b0;
`endif
    end else begin
      rx_state  <= rx_state_n;
      rx_cnt    <= rx_cnt_n;
      rx_shift  <= rx_shift_n;
      rx_idx    <= rx_idx_n;
      recv_en   <= recv_en_n;
      recv_data <= recv_data_n;
      recv_ferr <= recv_ferr_n;
`ifdef UART_PARITY_EN
      rx_perr   <= rx_perr_n;
      recv_perr <= recv_perr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_gen.sv
// Directed testbench for uart_gen: an 8N1 instance with switchable loopback, and a
// 5-data-bit, 2-stop-bit instance looped back on itself. Parity tests are built
// only when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_gen;

  localparam int DIV = 16;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME0 = (1 + 8 + P + 1) * DIV;
  localparam int FRAME1 = (1 + 5 + P + 2) * DIV;

  logic       clock = 1'b0;
  logic       reset0, reset1;
  logic       txd0, rxd0, loop0, drv_rxd0;
  logic       send_en0, send_ready0, recv_en0, recv_ferr0;
  logic [7:0] send_data0, recv_data0;
  logic       txd1, send_en1, send_ready1, recv_en1, recv_ferr1;
  logic [4:0] send_data1, recv_data1;
`ifdef UART_PARITY_EN
  logic       parity_odd0, recv_perr0, parity_odd1, recv_perr1, par_flip;
  logic       rx_perr_q[$];
`endif

  int vec_count = 0;
  int err_count = 0;

  logic [7:0] rx_data_q[$];
  logic       rx_ferr_q[$];
  logic [4:0] rx1_data_q[$];
  logic       rx1_ferr_q[$];

  always #5 clock = ~clock;

  assign rxd0 = loop0 ? txd0 : drv_rxd0;

  uart_gen #(.CLK_DIV(DIV), .DIV_WIDTH(11), .DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
    .clock(clock), .reset(reset0), .uart_txd(txd0), .uart_rxd(rxd0),
    .send_en(send_en0), .send_data(send_data0), .send_ready(send_ready0),
    .recv_en(recv_en0), .recv_data(recv_data0), .recv_ferr(recv_ferr0)
`ifdef UART_PARITY_EN
    , .parity_odd(parity_odd0), .recv_perr(recv_perr0)
`endif
  );

  uart_gen #(.CLK_DIV(DIV), .DIV_WIDTH(11), .DATA_BITS(5), .STOP_BITS(2)) u_dut1 (
    .clock(clock), .reset(reset1), .uart_txd(txd1), .uart_rxd(txd1),
    .send_en(send_en1), .send_data(send_data1), .send_ready(send_ready1),
    .recv_en(recv_en1), .recv_data(recv_data1), .recv_ferr(recv_ferr1)
`ifdef UART_PARITY_EN
    , .parity_odd(parity_odd1), .recv_perr(recv_perr1)
`endif
  );

  // Record every received character of both instances, one entry per recv_en cycle.
  always @(negedge clock) begin
    if (recv_en0 === 1'b1) begin
      rx_data_q.push_back(recv_data0);
      rx_ferr_q.push_back(recv_ferr0);
`ifdef UART_PARITY_EN
      rx_perr_q.push_back(recv_perr0);
`endif
    end
    if (recv_en1 === 1'b1) begin
      rx1_data_q.push_back(recv_data1);
      rx1_ferr_q.push_back(recv_ferr1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Bench-driven serial frame into instance 0 (loop0 must be 0).
  task automatic drive_frame(input logic [7:0] data, input logic stop_val);
    drv_rxd0 = 1'b0;
    cycles(DIV);
    for (int b = 0; b < 8; b++) begin
      drv_rxd0 = data[b];
      cycles(DIV);
    end
`ifdef UART_PARITY_EN
    drv_rxd0 = (^data) ^ parity_odd0 ^ par_flip;
    cycles(DIV);
`endif
    drv_rxd0 = stop_val;
    cycles(DIV);
  endtask

  task automatic clear_rx;
    rx_data_q.delete();
    rx_ferr_q.delete();
    rx1_data_q.delete();
    rx1_ferr_q.delete();
`ifdef UART_PARITY_EN
    rx_perr_q.delete();
`endif
  endtask

  task automatic test_reset;
    cycles(3);
    vec_count++; if (txd0 !== 1'b1) begin err_count++; $display("[TB] FAIL reset_txd0: got %b want 1", txd0); end
    vec_count++; if (send_ready0 !== 1'b1) begin err_count++; $display("[TB] FAIL reset_ready0: got %b want 1", send_ready0); end
    vec_count++; if (recv_en0 !== 1'b0) begin err_count++; $display("[TB] FAIL reset_recv_en0: got %b want 0", recv_en0); end
    vec_count++; if (recv_data0 !== 8'h00) begin err_count++; $display("[TB] FAIL reset_recv_data0: got %h want 00", recv_data0); end
    vec_count++; if (recv_ferr0 !== 1'b0) begin err_count++; $display("[TB] FAIL reset_ferr0: got %b want 0", recv_ferr0); end
    vec_count++; if (txd1 !== 1'b1) begin err_count++; $display("[TB] FAIL reset_txd1: got %b want 1", txd1); end
    vec_count++; if (send_ready1 !== 1'b1) begin err_count++; $display("[TB] FAIL reset_ready1: got %b want 1", send_ready1); end
    vec_count++; if (recv_data1 !== 5'h00) begin err_count++; $display("[TB] FAIL reset_recv_data1: got %h want 00", recv_data1); end
`ifdef UART_PARITY_EN
    vec_count++; if (recv_perr0 !== 1'b0) begin err_count++; $display("[TB] FAIL reset_perr0: got %b want 0", recv_perr0); end
`endif
    reset0 = 1'b0;
    reset1 = 1'b0;
    cycles(2);
  endtask

  task automatic test_tx_frame;
    logic [7:0] d;
    logic exp_txd, exp_par;
    int bitn;
    d = 8'hA5;
    exp_par = 1'b0;
`ifdef UART_PARITY_EN
    exp_par = (^d) ^ parity_odd0;
`endif
    loop0 = 1'b0;
    send_data0 = d;
    send_en0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send_en0 = 1'b0;
    for (int i = 0; i <= FRAME0; i++) begin
      bitn = i / DIV;
      if (bitn == 0)               exp_txd = 1'b0;
      else if (bitn <= 8)          exp_txd = d[bitn-1];
      else if (P == 1 && bitn == 9) exp_txd = exp_par;
      else                          exp_txd = 1'b1;
      vec_count++;
      if (txd0 !== exp_txd) begin
        err_count++; $display("[TB] FAIL tx_a5_txd[%0d]: got %b want %b", i, txd0, exp_txd);
      end
      vec_count++;
      if (send_ready0 !== (i == FRAME0)) begin
        err_count++; $display("[TB] FAIL tx_a5_ready[%0d]: got %b want %b", i, send_ready0, (i == FRAME0));
      end
      if (i < FRAME0) @(negedge clock);
    end
    cycles(4);
  endtask

  task automatic test_back_to_back;
    int k;
    clear_rx();
    loop0 = 1'b1;
    send_data0 = 8'h3C;
    send_en0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send_data0 = 8'hC3;
    cycles(FRAME0);
    vec_count++; if (send_ready0 !== 1'b1) begin err_count++; $display("[TB] FAIL b2b_gap_ready: got %b want 1", send_ready0); end
    @(negedge clock);
    vec_count++; if (send_ready0 !== 1'b0) begin err_count++; $display("[TB] FAIL b2b_second_accept: got %b want 0", send_ready0); end
    send_en0 = 1'b0;
    for (k = 0; k < 3 * FRAME0 && rx_data_q.size() < 2; k++) @(negedge clock);
    for (k = 0; k < 3 * FRAME0 && send_ready0 !== 1'b1; k++) @(negedge clock);
    cycles(DIV);
    vec_count++;
    if (rx_data_q.size() != 2) begin
      err_count++; $display("[TB] FAIL b2b_count: got %0d want 2", rx_data_q.size());
    end else begin
      vec_count++; if (rx_data_q[0] !== 8'h3C) begin err_count++; $display("[TB] FAIL b2b_data0: got %h want 3c", rx_data_q[0]); end
      vec_count++; if (rx_data_q[1] !== 8'hC3) begin err_count++; $display("[TB] FAIL b2b_data1: got %h want c3", rx_data_q[1]); end
      vec_count++; if (rx_ferr_q[0] !== 1'b0) begin err_count++; $display("[TB] FAIL b2b_ferr0: got %b want 0", rx_ferr_q[0]); end
      vec_count++; if (rx_ferr_q[1] !== 1'b0) begin err_count++; $display("[TB] FAIL b2b_ferr1: got %b want 0", rx_ferr_q[1]); end
    end
    loop0 = 1'b0;
    cycles(4);
  endtask

  task automatic test_glitch;
    clear_rx();
    drv_rxd0 = 1'b0;
    cycles(5);
    drv_rxd0 = 1'b1;
    cycles(40);
    vec_count++; if (rx_data_q.size() != 0) begin err_count++; $display("[TB] FAIL glitch_no_recv: got %0d want 0", rx_data_q.size()); end
    drive_frame(8'h81, 1'b1);
    cycles(20);
    vec_count++;
    if (rx_data_q.size() != 1) begin
      err_count++; $display("[TB] FAIL glitch_after_count: got %0d want 1", rx_data_q.size());
    end else begin
      vec_count++; if (rx_data_q[0] !== 8'h81) begin err_count++; $display("[TB] FAIL glitch_after_data: got %h want 81", rx_data_q[0]); end
      vec_count++; if (rx_ferr_q[0] !== 1'b0) begin err_count++; $display("[TB] FAIL glitch_after_ferr: got %b want 0", rx_ferr_q[0]); end
    end
  endtask

  task automatic test_break;
    clear_rx();
    drive_frame(8'h55, 1'b0);
    cycles(2000);
    vec_count++;
    if (rx_data_q.size() != 1) begin
      err_count++; $display("[TB] FAIL break_count: got %0d want 1", rx_data_q.size());
    end else begin
      vec_count++; if (rx_data_q[0] !== 8'h55) begin err_count++; $display("[TB] FAIL break_data: got %h want 55", rx_data_q[0]); end
      vec_count++; if (rx_ferr_q[0] !== 1'b1) begin err_count++; $display("[TB] FAIL break_ferr: got %b want 1", rx_ferr_q[0]); end
    end
    drv_rxd0 = 1'b1;
    cycles(20);
    vec_count++; if (rx_data_q.size() != 1) begin err_count++; $display("[TB] FAIL break_release_count: got %0d want 1", rx_data_q.size()); end
    drive_frame(8'h12, 1'b1);
    cycles(20);
    vec_count++;
    if (rx_data_q.size() != 2) begin
      err_count++; $display("[TB] FAIL break_next_count: got %0d want 2", rx_data_q.size());
    end else begin
      vec_count++; if (rx_data_q[1] !== 8'h12) begin err_count++; $display("[TB] FAIL break_next_data: got %h want 12", rx_data_q[1]); end
      vec_count++; if (rx_ferr_q[1] !== 1'b0) begin err_count++; $display("[TB] FAIL break_next_ferr: got %b want 0", rx_ferr_q[1]); end
    end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity;
    int k;
    clear_rx();
    parity_odd0 = 1'b1;
    loop0 = 1'b1;
    send_data0 = 8'h07;
    send_en0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send_en0 = 1'b0;
    cycles(9 * DIV + DIV / 2);
    vec_count++; if (txd0 !== 1'b0) begin err_count++; $display("[TB] FAIL parity_tx_bit: got %b want 0", txd0); end
    for (k = 0; k < 2 * FRAME0 && send_ready0 !== 1'b1; k++) @(negedge clock);
    cycles(4);
    vec_count++;
    if (rx_data_q.size() != 1) begin
      err_count++; $display("[TB] FAIL parity_loop_count: got %0d want 1", rx_data_q.size());
    end else begin
      vec_count++; if (rx_perr_q[0] !== 1'b0) begin err_count++; $display("[TB] FAIL parity_loop_perr: got %b want 0", rx_perr_q[0]); end
    end
    loop0 = 1'b0;
    cycles(4);
    clear_rx();
    par_flip = 1'b1;
    drive_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    cycles(20);
    vec_count++;
    if (rx_data_q.size() != 1) begin
      err_count++; $display("[TB] FAIL parity_bad_count: got %0d want 1", rx_data_q.size());
    end else begin
      vec_count++; if (rx_data_q[0] !== 8'h07) begin err_count++; $display("[TB] FAIL parity_bad_data: got %h want 07", rx_data_q[0]); end
      vec_count++; if (rx_perr_q[0] !== 1'b1) begin err_count++; $display("[TB] FAIL parity_bad_perr: got %b want 1", rx_perr_q[0]); end
      vec_count++; if (rx_ferr_q[0] !== 1'b0) begin err_count++; $display("[TB] FAIL parity_bad_ferr: got %b want 0", rx_ferr_q[0]); end
    end
    parity_odd0 = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe;
    logic [4:0] d;
    logic exp_txd;
    int bitn;
    d = 5'h1B;
    clear_rx();
    send_data1 = d;
    send_en1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send_en1 = 1'b0;
    cycles(70);
    vec_count++; if (send_ready1 !== 1'b0) begin err_count++; $display("[TB] FAIL mid_busy: got %b want 0", send_ready1); end
    reset1 = 1'b1;
    @(negedge clock);
    reset1 = 1'b0;
    vec_count++; if (txd1 !== 1'b1) begin err_count++; $display("[TB] FAIL mid_reset_txd: got %b want 1", txd1); end
    vec_count++; if (send_ready1 !== 1'b1) begin err_count++; $display("[TB] FAIL mid_reset_ready: got %b want 1", send_ready1); end
    cycles(40);
    vec_count++; if (rx1_data_q.size() != 0) begin err_count++; $display("[TB] FAIL mid_no_partial: got %0d want 0", rx1_data_q.size()); end
    vec_count++; if (txd1 !== 1'b1) begin err_count++; $display("[TB] FAIL mid_idle_txd: got %b want 1", txd1); end
    send_data1 = d;
    send_en1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    send_en1 = 1'b0;
    for (int i = 0; i <= FRAME1; i++) begin
      bitn = i / DIV;
      if (bitn == 0)      exp_txd = 1'b0;
      else if (bitn <= 5) exp_txd = d[bitn-1];
`ifdef UART_PARITY_EN
      else if (bitn == 6) exp_txd = (^d) ^ parity_odd1;
`endif
      else                exp_txd = 1'b1;
      vec_count++;
      if (txd1 !== exp_txd) begin
        err_count++; $display("[TB] FAIL resend_txd[%0d]: got %b want %b", i, txd1, exp_txd);
      end
      vec_count++;
      if (send_ready1 !== (i == FRAME1)) begin
        err_count++; $display("[TB] FAIL resend_ready[%0d]: got %b want %b", i, send_ready1, (i == FRAME1));
      end
      if (i < FRAME1) @(negedge clock);
    end
    cycles(4);
    vec_count++;
    if (rx1_data_q.size() != 1) begin
      err_count++; $display("[TB] FAIL resend_rx_count: got %0d want 1", rx1_data_q.size());
    end else begin
      vec_count++; if (rx1_data_q[0] !== 5'h1B) begin err_count++; $display("[TB] FAIL resend_rx_data: got %h want 1b", rx1_data_q[0]); end
      vec_count++; if (rx1_ferr_q[0] !== 1'b0) begin err_count++; $display("[TB] FAIL resend_rx_ferr: got %b want 0", rx1_ferr_q[0]); end
    end
  endtask

  // Directed test sequence.
  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    send_en0 = 1'b0;
    send_en1 = 1'b0;
    send_data0 = 8'h00;
    send_data1 = 5'h00;
    loop0 = 1'b0;
    drv_rxd0 = 1'b1;
`ifdef UART_PARITY_EN
    parity_odd0 = 1'b0;
    parity_odd1 = 1'b0;
    par_flip = 1'b0;
`endif
    $display("[TB] uart_gen directed tests, CLK_DIV=%0d", DIV);
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_glitch();
    test_break();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
